// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: h/v counters, sync pulses, active window and line/frame markers.
// Optional line-buffer prefetch request enabled by defining LINE_REQ_EN.
`timescale 1ns/1ps
module vga_timing_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start
`ifdef LINE_REQ_EN
  ,
  output logic       line_req,
  output logic [9:0] line_req_y
`endif
);

  localparam logic [9:0] H_ACT_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_LAST   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_LAST   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic       SYNC_OFF    = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic       SYNC_ON     = ~SYNC_OFF;

  typedef enum logic [1:0] {ST_ACTIVE, ST_FP, ST_SYNC, ST_BP} seg_e;

  seg_e       h_state_q, h_state_d, v_state_q, v_state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;
  logic       line_start_d, frame_start_d;
  logic       h_wrap;

  assign h_wrap = pixel_tick && (x_q == H_LAST);

  // NOTE: every variable gets a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    h_state_d     = h_state_q;
    v_state_d     = v_state_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pixel_tick) begin
      x_d = h_wrap ? 10'd0 : x_q + 10'd1;
      case (h_state_q)
        ST_ACTIVE: if (x_q == H_ACT_LAST)  h_state_d = ST_FP;
        ST_FP:     if (x_q == H_FP_LAST)   h_state_d = ST_SYNC;
        ST_SYNC:   if (x_q == H_SYNC_LAST) h_state_d = ST_BP;
        ST_BP:     if (x_q == H_LAST)      h_state_d = ST_ACTIVE;
      endcase
    end
    if (h_wrap) begin
      line_start_d  = 1'b1;
      frame_start_d = (y_q == V_LAST);
      y_d           = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
      case (v_state_q)
        ST_ACTIVE: if (y_q == V_ACT_LAST)  v_state_d = ST_FP;
        ST_FP:     if (y_q == V_FP_LAST)   v_state_d = ST_SYNC;
        ST_SYNC:   if (y_q == V_SYNC_LAST) v_state_d = ST_BP;
        ST_BP:     if (y_q == V_LAST)      v_state_d = ST_ACTIVE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q           <= H_LAST;
      y_q           <= V_LAST;
      h_state_q     <= ST_BP;
      v_state_q     <= ST_BP;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      hsync_q       <= (h_state_d == ST_SYNC) ? SYNC_ON : SYNC_OFF;
      vsync_q       <= (v_state_d == ST_SYNC) ? SYNC_ON : SYNC_OFF;
      video_on_q    <= (h_state_d == ST_ACTIVE) && (v_state_d == ST_ACTIVE);
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef LINE_REQ_EN
  // Request the next line while entering h SYNC, but only when that line will be displayed.
  logic [9:0] next_line;
  logic       line_req_q, line_req_d;
  logic [9:0] line_req_y_q, line_req_y_d;

  always_comb begin
    next_line    = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
    line_req_d   = pixel_tick && (x_q == H_FP_LAST) && (next_line <= V_ACT_LAST);
    line_req_y_d = line_req_d ? next_line : line_req_y_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_req_q   <= 1'b0;
      line_req_y_q <= 10'd0;
    end else begin
      line_req_q   <= line_req_d;
      line_req_y_q <= line_req_y_d;
    end
  end

  assign line_req   = line_req_q;
  assign line_req_y = line_req_y_q;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench for vga_timing_ctrl: a standard-timing instance and a tiny-raster instance
// are both compared every clk against a position-based model; define LINE_REQ_EN to check requests.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    bit act_low;
  } cfg_t;

  typedef struct packed {
    int x; int y; bit ls; bit fs; bit req; int req_y;
  } mstate_t;

  localparam cfg_t CFG0 = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33, act_low:1'b1};
  localparam cfg_t CFG1 = '{ha:8, hfp:2, hs:3, hbp:3, va:6, vfp:2, vs:2, vbp:3, act_low:1'b0};

  logic       clk = 1'b0;
  logic [1:0] rst_v = 2'b00;
  logic [1:0] tick_v = 2'b00;
  always #5 clk = ~clk;

  logic       hs0, vs0, von0, ls0, fs0, hs1, vs1, von1, ls1, fs1;
  logic [9:0] px0, py0, px1, py1;
  logic       req0, req1;
  logic [9:0] reqy0, reqy1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  vga_timing_ctrl u0 (
    .clk(clk), .reset(rst_v[0]), .pixel_tick(tick_v[0]),
    .hsync(hs0), .vsync(vs0), .video_on(von0), .pixel_x(px0), .pixel_y(py0),
    .line_start(ls0), .frame_start(fs0)
`ifdef LINE_REQ_EN
    , .line_req(req0), .line_req_y(reqy0)
`endif
  );

  vga_timing_ctrl #(
    .H_ACTIVE(CFG1.ha), .H_FP(CFG1.hfp), .H_SYNC(CFG1.hs), .H_BP(CFG1.hbp),
    .V_ACTIVE(CFG1.va), .V_FP(CFG1.vfp), .V_SYNC(CFG1.vs), .V_BP(CFG1.vbp),
    .SYNC_ACTIVE_LOW(int'(CFG1.act_low))
  ) u1 (
    .clk(clk), .reset(rst_v[1]), .pixel_tick(tick_v[1]),
    .hsync(hs1), .vsync(vs1), .video_on(von1), .pixel_x(px1), .pixel_y(py1),
    .line_start(ls1), .frame_start(fs1)
`ifdef LINE_REQ_EN
    , .line_req(req1), .line_req_y(reqy1)
`endif
  );

`ifndef LINE_REQ_EN
  assign req0 = 1'b0; assign reqy0 = 10'd0;
  assign req1 = 1'b0; assign reqy1 = 10'd0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: raster position walked with modular arithmetic
  function automatic int htot(cfg_t c); return c.ha + c.hfp + c.hs + c.hbp; endfunction
  function automatic int vtot(cfg_t c); return c.va + c.vfp + c.vs + c.vbp; endfunction

  function automatic mstate_t m_reset(cfg_t c);
    mstate_t m;
    m = '0;
    m.x = htot(c) - 1;
    m.y = vtot(c) - 1;
    return m;
  endfunction

  function automatic mstate_t m_step(cfg_t c, mstate_t s, bit tick);
    mstate_t n;
    n = s; n.ls = 0; n.fs = 0; n.req = 0;
    if (tick) begin
      n.x = (s.x + 1) % htot(c);
      if (n.x == 0) begin
        n.ls = 1;
        n.y  = (s.y + 1) % vtot(c);
        n.fs = (n.y == 0);
      end
      if (n.x == c.ha + c.hfp && (n.y + 1) % vtot(c) < c.va) begin
        n.req   = 1;
        n.req_y = (n.y + 1) % vtot(c);
      end
    end
    return n;
  endfunction

  mstate_t m0, m1;
  always @(posedge clk or posedge rst_v[0])
    if (rst_v[0]) m0 <= m_reset(CFG0); else m0 <= m_step(CFG0, m0, tick_v[0]);
  always @(posedge clk or posedge rst_v[1])
    if (rst_v[1]) m1 <= m_reset(CFG1); else m1 <= m_step(CFG1, m1, tick_v[1]);

  task automatic compare_outputs(input string p, input cfg_t c, input mstate_t m,
                                 input logic hs, input logic vs, input logic von,
                                 input logic [9:0] px, input logic [9:0] py,
                                 input logic ls, input logic fs,
                                 input logic req, input logic [9:0] reqy);
    bit in_hs, in_vs;
    in_hs = (m.x >= c.ha + c.hfp) && (m.x < c.ha + c.hfp + c.hs);
    in_vs = (m.y >= c.va + c.vfp) && (m.y < c.va + c.vfp + c.vs);
    check({p, ".pixel_x"}, 32'(px), m.x);
    check({p, ".pixel_y"}, 32'(py), m.y);
    check({p, ".hsync"}, 32'(hs), 32'(in_hs ? !c.act_low : c.act_low));
    check({p, ".vsync"}, 32'(vs), 32'(in_vs ? !c.act_low : c.act_low));
    check({p, ".video_on"}, 32'(von), 32'(m.x < c.ha && m.y < c.va));
    check({p, ".line_start"}, 32'(ls), 32'(m.ls));
    check({p, ".frame_start"}, 32'(fs), 32'(m.fs));
`ifdef LINE_REQ_EN
    check({p, ".line_req"}, 32'(req), 32'(m.req));
    check({p, ".line_req_y"}, 32'(reqy), m.req_y);
`endif
  endtask

  always @(negedge clk) if (cmp_en) begin
    compare_outputs("u0", CFG0, m0, hs0, vs0, von0, px0, py0, ls0, fs0, req0, reqy0);
    compare_outputs("u1", CFG1, m1, hs1, vs1, von1, px1, py1, ls1, fs1, req1, reqy1);
  end

  // ---------------- tiny-raster event counters for the multi-frame run
  bit ticked1 = 1'b0;
  bit mon1_en = 1'b0;
  int hs_cnt1 = 0, vs_cnt1 = 0, von_cnt1 = 0, fs_cnt1 = 0, req_cnt1 = 0;
  always @(posedge clk) ticked1 <= tick_v[1];
  always @(negedge clk) if (mon1_en && ticked1) begin
    hs_cnt1  += int'(hs1 == !CFG1.act_low);
    vs_cnt1  += int'(vs1 == !CFG1.act_low);
    von_cnt1 += int'(von1);
    fs_cnt1  += int'(fs1);
    req_cnt1 += int'(req1);
  end

  // n ticks with 0..max_gap idle clks before each; called at a negedge, returns at a negedge
  task automatic run_ticks(input int idx, input int n, input int max_gap);
    int gap;
    for (int i = 0; i < n; i++) begin
      gap = int'($urandom_range(max_gap, 0));
      tick_v[idx] = 1'b0;
      repeat (gap) @(negedge clk);
      tick_v[idx] = 1'b1;
      @(negedge clk);
    end
    tick_v[idx] = 1'b0;
  endtask

  task automatic seq_std();
    int hs_low, von_cnt, ls_cnt, first_hs, ls_x, pulses, req_cnt, req_y_seen;
    check("u0.reset_x", 32'(px0), 799);
    check("u0.reset_y", 32'(py0), 524);
    check("u0.reset_video_on", 32'(von0), 0);
    check("u0.reset_hsync", 32'(hs0), 1);
    check("u0.reset_vsync", 32'(vs0), 1);
    rst_v[0] = 1'b0;
    @(negedge clk);
    run_ticks(0, 1, 0);
    check("u0.first_x", 32'(px0), 0);
    check("u0.first_y", 32'(py0), 0);
    check("u0.first_video_on", 32'(von0), 1);
    check("u0.first_line_start", 32'(ls0), 1);
    check("u0.first_frame_start", 32'(fs0), 1);
    @(negedge clk);
    check("u0.line_start_drop", 32'(ls0), 0);
    check("u0.frame_start_drop", 32'(fs0), 0);

    // one line, tick every 4th clk
    hs_low = 0; von_cnt = 0; ls_cnt = 0; first_hs = -1; ls_x = -1; req_cnt = 0; req_y_seen = -1;
    for (int i = 0; i < 800; i++) begin
      tick_v[0] = 1'b1;
      @(negedge clk);
      tick_v[0] = 1'b0;
      if (!hs0) begin hs_low++; if (first_hs < 0) first_hs = int'(px0); end
      if (von0) von_cnt++;
      if (ls0) begin ls_cnt++; ls_x = int'(px0); end
      if (req0) begin req_cnt++; req_y_seen = int'(reqy0); end
      repeat (3) @(negedge clk);
    end
    check("u0.line_hsync_ticks", hs_low, 96);
    check("u0.line_hsync_first_x", first_hs, 656);
    check("u0.line_video_ticks", von_cnt, 640);
    check("u0.line_start_count", ls_cnt, 1);
    check("u0.line_start_x", ls_x, 0);
`ifdef LINE_REQ_EN
    check("u0.line_req_count", req_cnt, 1);
    check("u0.line_req_y_value", req_y_seen, 1);
`endif

    // freeze mid-line at x = 300
    run_ticks(0, 300, 3);
    check("u0.pre_hold_x", 32'(px0), 300);
    pulses = 0;
    repeat (100) begin
      @(negedge clk);
      pulses += int'(ls0) + int'(fs0) + int'(req0);
    end
    check("u0.hold_x", 32'(px0), 300);
    check("u0.hold_y", 32'(py0), 1);
    check("u0.hold_pulses", pulses, 0);

    // tick held high across the line wrap
    tick_v[0] = 1'b1;
    repeat (499) @(negedge clk);
    check("u0.cont_x799", 32'(px0), 799);
    @(negedge clk);
    check("u0.cont_wrap_x", 32'(px0), 0);
    check("u0.cont_wrap_y", 32'(py0), 2);
    check("u0.cont_wrap_ls", 32'(ls0), 1);
    @(negedge clk);
    check("u0.cont_after_x", 32'(px0), 1);
    check("u0.cont_after_ls", 32'(ls0), 0);
    tick_v[0] = 1'b0;

    // asynchronous reset mid-line
    run_ticks(0, 399, 2);
    check("u0.pre_reset_x", 32'(px0), 400);
    #2 rst_v[0] = 1'b1;
    #1;
    check("u0.async_reset_x", 32'(px0), 799);
    check("u0.async_reset_y", 32'(py0), 524);
    check("u0.async_reset_video_on", 32'(von0), 0);
    check("u0.async_reset_hsync", 32'(hs0), 1);
    @(negedge clk);
    rst_v[0] = 1'b0;
    @(negedge clk);
    run_ticks(0, 1, 0);
    check("u0.resume_x", 32'(px0), 0);
    check("u0.resume_y", 32'(py0), 0);
    check("u0.resume_frame_start", 32'(fs0), 1);

    run_ticks(0, 3000, 3);
  endtask

  task automatic seq_tiny();
    check("u1.reset_x", 32'(px1), 15);
    check("u1.reset_y", 32'(py1), 12);
    check("u1.reset_vsync", 32'(vs1), 0);
    rst_v[1] = 1'b0;
    @(negedge clk);
    run_ticks(1, 1, 0);
    check("u1.first_frame_start", 32'(fs1), 1);
    #1 mon1_en = 1'b1;
    run_ticks(1, 3 * 16 * 13, 2);
    #1 mon1_en = 1'b0;
    check("u1.frames_x", 32'(px1), 0);
    check("u1.frames_y", 32'(py1), 0);
    check("u1.frame_start_count", fs_cnt1, 3);
    check("u1.hsync_ticks", hs_cnt1, 117);
    check("u1.vsync_ticks", vs_cnt1, 96);
    check("u1.video_ticks", von_cnt1, 144);
`ifdef LINE_REQ_EN
    check("u1.line_req_count", req_cnt1, 18);
`endif
    @(negedge clk);
    run_ticks(1, 50, 2);
    #2 rst_v[1] = 1'b1;
    #1;
    check("u1.async_reset_x", 32'(px1), 15);
    check("u1.async_reset_y", 32'(py1), 12);
    check("u1.async_reset_hsync", 32'(hs1), 0);
    @(negedge clk);
    rst_v[1] = 1'b0;
    @(negedge clk);
    run_ticks(1, 500, 2);
  endtask

  initial begin
    #1 rst_v = 2'b11;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    fork
      seq_std();
      seq_tiny();
    join
    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Sequences VGA raster scan from the 25 MHz pixel-tick strobe produced by the pixel clock divider.
- Generates horizontal and vertical counters, sync pulses, the active-video window, and frame/line markers.
- These outputs drive the convolution output stage and the scan-out pixel pipeline.
- Counters advance only on clk edges where pixel_tick is high; all logic runs in the single clk domain.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync driven low during the pulse; 0 = driven high

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pixel_tick  input  1  one-clk strobe, nominally 1 in every 4 clk
- hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- video_on  output  1  high while (pixel_x, pixel_y) is inside the active window
- pixel_x  output  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  output  10  current vertical count, 0..V_TOTAL-1
- line_start  output  1  one-clk pulse when pixel_x wraps to 0
- frame_start  output  1  one-clk pulse when (pixel_x, pixel_y) wraps to (0,0)
- line_req  output  1  present only with LINE_REQ_EN; see Optional Feature
- line_req_y  output  10  present only with LINE_REQ_EN; see Optional Feature

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525. Counters are 10 bits; parameters must give totals ≤ 1024.
- Reset (asynchronous, takes effect immediately):
  - pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1.
  - video_on = 0, line_start = 0, frame_start = 0.
  - hsync and vsync at inactive level (1 when SYNC_ACTIVE_LOW = 1).
  - h_state = BP, v_state = BP.
- After reset deasserts, the first pixel_tick moves the counters to (0,0) and pulses both line_start and frame_start.
- Horizontal FSM, advancing one step per tick:
  - ACTIVE: x in 0..H_ACTIVE-1.
  - FP: x in H_ACTIVE..H_ACTIVE+H_FP-1.
  - SYNC: x in 656..751.
  - BP: x in 752..799.
  - BP wraps to ACTIVE with x = 0.
- Vertical FSM, same four states over y:
  - ACTIVE: 0..479.
  - FP: 480..489.
  - SYNC: 490..491.
  - BP: 492..524.
  - Advances only on a tick where x = H_TOTAL-1, i.e. on the horizontal wrap.
  - y = V_TOTAL-1 combined with the horizontal wrap gives y = 0.
- All outputs are registered and update on the same clk edge as the counters.
  - No combinational path from pixel_tick to any output.
  - Latency from a tick to the updated outputs is 1 clk.
- hsync is asserted exactly while h_state = SYNC. vsync is asserted exactly while v_state = SYNC.
- video_on = (h_state == ACTIVE) && (v_state == ACTIVE).
- line_start and frame_start:
  - High for exactly one clk, on the edge where the wrap occurs.
  - Low otherwise, even if pixel_tick stays high on consecutive clks.
- With pixel_tick held low, every output holds indefinitely. The pulse outputs drop to 0 after one clk.
- Consecutive-clk ticks (pixel_tick held high) advance the counters once per clk; no tick is dropped.
- A reset asserted mid-frame returns the block to the reset state at once. Counting resumes from the reset state on the first tick after reset deasserts.

Optional Feature:
- Macro: LINE_REQ_EN.
- When defined:
  - Adds ports line_req and line_req_y.
  - line_req pulses for one clk on the tick where x transitions to H_ACTIVE+H_FP, i.e. entering h SYNC.
  - The pulse fires only when the next line (y+1, wrapping at V_TOTAL to 0) is an active line (< V_ACTIVE).
  - line_req_y carries that next-line index and holds it until the next request.
  - line_req_y resets to 0; line_req resets to 0.
  - Purpose: prefetch a line into the convolution line buffer.
- When undefined: neither port exists and no request logic is synthesized.

Test Plan:
- Reset, release, one tick:
  - Before the tick: (799,524), video_on = 0, hsync = vsync = 1.
  - After the tick: (0,0), video_on = 1, frame_start and line_start each high for 1 clk.
- Ticks every 4th clk for one full line:
  - hsync low for exactly 96 ticks, starting on x = 656.
  - video_on high for 640 ticks.
  - line_start pulses once, at x = 0.
- Full frame: 420000 ticks from (0,0):
  - vsync low during y = 490..491 only.
  - frame_start pulses exactly once, after the 420000th tick returns to (0,0).
- pixel_tick held low for 100 clk mid-line at x = 300: all outputs frozen, no pulses.
- pixel_tick held high continuously: the counter advances every clk; the x = 799 wrap takes exactly one clk.
- Reset asserted at (400,200): outputs return to reset values immediately, without waiting for a clk edge.
- With LINE_REQ_EN: line_req pulses at (656, y) for y = 524 and for y = 0..478, with line_req_y = y+1 mod 525. No pulse for y = 479..523.
